minmax_window: RTL and testbench

Parametrised running-extremum tracker; successor to the scalar min/max block. Accepts a valid-qualified sample stream and reports min and max in one of two modes, selectable at run time: cumulative since reset/clear, or over a sliding window of the last DEPTH samples. Adds signed/unsigned compare, synchronous clear, a sample counter and an output-valid strobe. Sits in the sequential-logic lab set as a streaming statistics stage.

---
 rtl/minmax_window.sv | 74 +++++++
 tb/tb_minmax_window.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/minmax_window.sv
// minmax_window: running min/max, cumulative or over a sliding window of the last DEPTH samples
module minmax_window #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       num,
  input  logic                   win_en,
  output logic [WIDTH-1:0]       min,
  output logic [WIDTH-1:0]       max,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [WIDTH-1:0] r_cmin, r_cmax;
  logic             r_first;
  logic             w_acc;
  logic [WIDTH-1:0] w_wmin, w_wmax, w_cmin, w_cmax;
  function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return SIGNED ? ($signed(a) < $signed(b)) : (a < b);
  endfunction
  assign w_acc  = in_valid & ~clr;
  assign w_cmin = (r_first || lt(num, r_cmin)) ? num : r_cmin;
  assign w_cmax = (r_first || lt(r_cmax, num)) ? num : r_cmax;
  // Slot wr_ptr holds the oldest sample once full; num replaces it, so only the newest DEPTH-1 slots count
  always_comb begin
    w_wmin = num;
    w_wmax = num;
    for (int k = 1; k < DEPTH; k++) begin
      w_wmin = ((AW+1)'(k) <= count && lt(r_buf[r_wr_ptr - AW'(k)], w_wmin)) ? r_buf[r_wr_ptr - AW'(k)] : w_wmin;
      w_wmax = ((AW+1)'(k) <= count && lt(w_wmax, r_buf[r_wr_ptr - AW'(k)])) ? r_buf[r_wr_ptr - AW'(k)] : w_wmax;
    end
  end
  always_ff @(posedge clk)
    if (w_acc) r_buf[r_wr_ptr] <= num;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min       <= '0;
      max       <= '0;
      out_valid <= 1'b0;
      count     <= '0;
      r_wr_ptr  <= '0;
      r_cmin    <= '0;
      r_cmax    <= '0;
      r_first   <= 1'b1;
    end else if (clr) begin
      min       <= '0;
      max       <= '0;
      out_valid <= 1'b0;
      count     <= '0;
      r_wr_ptr  <= '0;
      r_cmin    <= '0;
      r_cmax    <= '0;
      r_first   <= 1'b1;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        count    <= (count == (AW+1)'(DEPTH)) ? count : count + (AW+1)'(1);
        r_cmin   <= w_cmin;
        r_cmax   <= w_cmax;
        r_first  <= 1'b0;
        min      <= win_en ? w_wmin : w_cmin;
        max      <= win_en ? w_wmax : w_cmax;
      end
    end
  end
endmodule

// File: tb/tb_minmax_window.sv
// tb_minmax_window: table, directed and random checks of minmax_window against a history-based model
module tb_minmax_window;
  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, in_valid = 1'b0, win_en = 1'b0;
  logic [31:0] num = '0;
  always #5 clk = ~clk;
  logic [31:0] a_min, a_max, b_min, b_max, c_min, c_max;
  logic [1:0]  d_min, d_max;
  logic [2:0]  a_cnt, b_cnt;
  logic [1:0]  c_cnt, d_cnt;
  logic        a_ov, b_ov, c_ov, d_ov;
  minmax_window #(.WIDTH(32), .DEPTH(4), .SIGNED(1)) u_a (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .num(num), .win_en(win_en), .min(a_min), .max(a_max), .out_valid(a_ov), .count(a_cnt));
  minmax_window #(.WIDTH(32), .DEPTH(4), .SIGNED(0)) u_b (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .num(num), .win_en(win_en), .min(b_min), .max(b_max), .out_valid(b_ov), .count(b_cnt));
  minmax_window #(.WIDTH(32), .DEPTH(2), .SIGNED(1)) u_c (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .num(num), .win_en(win_en), .min(c_min), .max(c_max), .out_valid(c_ov), .count(c_cnt));
  minmax_window #(.WIDTH(2), .DEPTH(2), .SIGNED(0)) u_d (.clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .num(num[1:0]), .win_en(win_en), .min(d_min), .max(d_max), .out_valid(d_ov), .count(d_cnt));
  localparam int PW [4] = '{32, 32, 32, 2};
  localparam int PD [4] = '{4, 4, 2, 2};
  localparam int PS [4] = '{1, 0, 1, 0};
  int checks = 0, errors = 0;
  logic [31:0] hist [$];
  logic [31:0] e_min [4], e_max [4];
  int          e_cnt [4];
  bit          e_ov  [4];
  typedef struct {
    bit c, v, w;
    logic [31:0] n, mn, mx;
    int cn;
    bit ov;
  } vec_t;
  vec_t tbl [$];
  function automatic logic [31:0] mask(int i);
    return 32'((64'd1 << PW[i]) - 64'd1);
  endfunction
  function automatic longint sv(logic [31:0] x, int i);
    longint v = longint'(x & mask(i));
    if (PS[i] != 0 && v[PW[i]-1]) v -= longint'(64'd1 << PW[i]);
    return v;
  endfunction
  function automatic void model_clear();
    hist.delete();
    foreach (e_min[i]) begin
      e_min[i] = '0; e_max[i] = '0; e_cnt[i] = 0; e_ov[i] = 1'b0;
    end
  endfunction
  function automatic void model_accept(logic [31:0] n, bit w);
    hist.push_back(n);
    foreach (e_min[i]) begin
      int sz = hist.size();
      int used = w ? ((sz < PD[i]) ? sz : PD[i]) : sz;
      longint lo = sv(n, i);
      longint hi = lo;
      for (int k = sz - used; k < sz; k++) begin
        longint x = sv(hist[k], i);
        if (x < lo) lo = x;
        if (x > hi) hi = x;
      end
      e_min[i] = 32'(lo) & mask(i);
      e_max[i] = 32'(hi) & mask(i);
      e_cnt[i] = (sz < PD[i]) ? sz : PD[i];
      e_ov[i]  = 1'b1;
    end
  endfunction
  task automatic cmp(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic check_model(string tag);
    logic [31:0] mn [4];
    logic [31:0] mx [4];
    int cn [4];
    bit ov [4];
    mn = '{a_min, b_min, c_min, {30'b0, d_min}};
    mx = '{a_max, b_max, c_max, {30'b0, d_max}};
    cn = '{int'(a_cnt), int'(b_cnt), int'(c_cnt), int'(d_cnt)};
    ov = '{a_ov, b_ov, c_ov, d_ov};
    for (int i = 0; i < 4; i++) begin
      cmp($sformatf("%s u%0d min", tag, i), mn[i], e_min[i]);
      cmp($sformatf("%s u%0d max", tag, i), mx[i], e_max[i]);
      cmp($sformatf("%s u%0d count", tag, i), cn[i], e_cnt[i]);
      cmp($sformatf("%s u%0d out_valid", tag, i), ov[i], e_ov[i]);
    end
  endtask
  task automatic cyc(bit c, bit v, bit w, logic [31:0] n);
    clr = c; in_valid = v; win_en = w; num = n;
    @(posedge clk);
    if (c) model_clear();
    else if (v) model_accept(n, w);
    else foreach (e_ov[i]) e_ov[i] = 1'b0;
    #1;
  endtask
  task automatic a_chk(string nm, logic [31:0] mn, logic [31:0] mx, int cn, bit ov);
    cmp({nm, " min"}, a_min, mn);
    cmp({nm, " max"}, a_max, mx);
    cmp({nm, " count"}, a_cnt, cn);
    cmp({nm, " out_valid"}, a_ov, ov);
  endtask
  task automatic async_reset(string tag);
    #3 rst = 1'b0;
    model_clear();
    #1 check_model(tag);
    cmp({tag, " a_min"}, a_min, 0);
    cmp({tag, " a_cnt"}, a_cnt, 0);
    #2 rst = 1'b1;
  endtask
  initial begin
    bit w;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    a_chk("reset", 0, 0, 0, 0);
    check_model("reset");
    rst = 1'b1;
    tbl.push_back(vec_t'{0, 1, 0, 2, 2, 2, 1, 1});
    tbl.push_back(vec_t'{0, 1, 0, 1, 1, 2, 2, 1});
    tbl.push_back(vec_t'{0, 1, 0, 3, 1, 3, 3, 1});
    tbl.push_back(vec_t'{0, 1, 0, 0, 0, 3, 4, 1});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 3, 4, 0});
    tbl.push_back(vec_t'{1, 1, 0, 100, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 1, 1, 5, 5, 5, 1, 1});
    tbl.push_back(vec_t'{0, 1, 1, 9, 5, 9, 2, 1});
    tbl.push_back(vec_t'{0, 1, 1, 1, 1, 9, 3, 1});
    tbl.push_back(vec_t'{0, 1, 1, 7, 1, 9, 4, 1});
    tbl.push_back(vec_t'{0, 1, 1, 8, 1, 9, 4, 1});
    tbl.push_back(vec_t'{0, 1, 1, 6, 1, 8, 4, 1});
    tbl.push_back(vec_t'{0, 1, 1, 10, 6, 10, 4, 1});
    tbl.push_back(vec_t'{0, 0, 0, 0, 6, 10, 4, 0});
    tbl.push_back(vec_t'{0, 1, 0, 2, 1, 10, 4, 1});
    foreach (tbl[i]) begin
      cyc(tbl[i].c, tbl[i].v, tbl[i].w, tbl[i].n);
      a_chk($sformatf("tbl%0d", i), tbl[i].mn, tbl[i].mx, tbl[i].cn, tbl[i].ov);
      check_model($sformatf("tbl%0d", i));
    end
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 32'hFFFFFFFD);
    cyc(0, 1, 0, 4);
    cmp("signed min", a_min, 32'hFFFFFFFD);
    cmp("signed max", a_max, 4);
    cmp("unsigned min", b_min, 4);
    cmp("unsigned max", b_max, 32'hFFFFFFFD);
    check_model("sign");
    cyc(0, 1, 0, 20);
    cyc(1, 1, 0, 100);
    a_chk("clr", 0, 0, 0, 0);
    check_model("clr");
    cyc(0, 1, 0, 7);
    a_chk("clr cum", 7, 7, 1, 1);
    cyc(1, 0, 1, 0);
    cyc(0, 1, 1, 7);
    a_chk("clr win", 7, 7, 1, 1);
    check_model("clr win");
    cyc(0, 1, 1, 50);
    cyc(0, 1, 1, 60);
    async_reset("rst mid");
    cyc(0, 1, 1, 4);
    a_chk("after rst", 4, 4, 1, 1);
    check_model("after rst");
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 3);
    cyc(0, 1, 0, 8);
    cmp("gap c_min", c_min, 3);
    cmp("gap c_max", c_max, 8);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      cmp($sformatf("idle%0d c_max", i), c_max, 8);
      cmp($sformatf("idle%0d c_ov", i), c_ov, 0);
    end
    cyc(0, 0, 1, 0);
    cmp("toggle c_min", c_min, 3);
    cmp("toggle c_max", c_max, 8);
    cyc(0, 1, 1, 5);
    cmp("win2 c_min", c_min, 5);
    cmp("win2 c_max", c_max, 8);
    cmp("win2 c_cnt", c_cnt, 2);
    check_model("win2");
    w = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      logic [31:0] n;
      logic [31:0] edges [7];
      edges = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h2, 32'h3};
      case ($urandom_range(0, 3))
        0: n = $urandom;
        1: n = $urandom_range(0, 7);
        2: n = edges[$urandom_range(0, 6)];
        default: n = -$urandom_range(0, 7);
      endcase
      if ($urandom_range(0, 7) == 0) w = ~w;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, w, n);
      check_model("rand");
      if ($urandom_range(0, 299) == 0) async_reset("rand rst");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
